// File: rtl/fifo_rd_serializer.sv
// Pops wide words from a first-word-fall-through FIFO and streams them out as RATIO narrow valid/ready beats.
// Optional stall counter (stall_cnt/stall_clr) is built when FIFO_RD_SER_STALL_CNT_EN is defined.
module fifo_rd_serializer #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned OUT_WIDTH = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rest,
    input  logic                 flush,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
    input  logic [IN_WIDTH-1:0]  fifo_read_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef FIFO_RD_SER_STALL_CNT_EN
    ,
    input  logic                 stall_clr,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int unsigned RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_cfg_err
        $error("fifo_rd_serializer: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                hold_valid_q, hold_valid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    slice_idx;
    logic                at_last;
    logic                xfer;

    // Pop/advance decisions; flush outranks both reload and beat advance.
    always_comb begin
        hold_data_d  = hold_data_q;
        hold_valid_d = hold_valid_q;
        cnt_d        = cnt_q;

        at_last   = (cnt_q == CNT_LAST);
        xfer      = hold_valid_q && out_ready;
        fifo_read = !rest && !flush && !fifo_empty && (!hold_valid_q || (out_ready && at_last));

        if (flush) begin
            hold_valid_d = 1'b0;
            cnt_d        = '0;
        end else if (fifo_read) begin
            hold_data_d  = fifo_read_data;
            hold_valid_d = 1'b1;
            cnt_d        = '0;
        end else if (xfer) begin
            if (at_last) begin
                hold_valid_d = 1'b0;
                cnt_d        = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // Beat k maps to slice k (LSB first) or slice RATIO-1-k (MSB first).
    always_comb begin
        slice_idx = LSB_FIRST ? cnt_q : (CNT_LAST - cnt_q);
        out_data  = OUT_WIDTH'(hold_data_q >> (32'(slice_idx) * OUT_WIDTH));
        out_valid = hold_valid_q;
        busy      = hold_valid_q;
        out_last  = hold_valid_q && at_last;
    end

`ifdef FIFO_RD_SER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles a beat waited on out_ready.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush || stall_clr) begin
            stall_cnt_d = '0;
        end else if (hold_valid_q && !out_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: an LSB-first and an MSB-first instance share one FIFO model and one beat-queue model.
module tb_fifo_rd_serializer;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        flush = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        out_ready = 1'b0;
    logic        stall_clr = 1'b0;
    logic [31:0] fifo_read_data = '0;

    logic       rd_l, v_l, last_l, busy_l;
    logic       rd_m, v_m, last_m, busy_m;
    logic [7:0] d_l, d_m;
`ifdef FIFO_RD_SER_STALL_CNT_EN
    logic [15:0] sc_l, sc_m;
`endif

    always #5 clk = ~clk;

    fifo_rd_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rest(rest), .flush(flush), .fifo_empty(fifo_empty), .fifo_read(rd_l),
        .fifo_read_data(fifo_read_data), .out_valid(v_l), .out_ready(out_ready),
        .out_data(d_l), .out_last(last_l), .busy(busy_l)
`ifdef FIFO_RD_SER_STALL_CNT_EN
        , .stall_clr(stall_clr), .stall_cnt(sc_l)
`endif
    );

    fifo_rd_serializer #(.IN_WIDTH(32), .OUT_WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rest(rest), .flush(flush), .fifo_empty(fifo_empty), .fifo_read(rd_m),
        .fifo_read_data(fifo_read_data), .out_valid(v_m), .out_ready(out_ready),
        .out_data(d_m), .out_last(last_m), .busy(busy_m)
`ifdef FIFO_RD_SER_STALL_CNT_EN
        , .stall_clr(stall_clr), .stall_cnt(sc_m)
`endif
    );

    // Model: FIFO contents, remaining beats of the held word in each order, stall count.
    logic [31:0] fq[$];
    logic [7:0]  ml[$];
    logic [7:0]  mm[$];
    int unsigned sc = 0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic exp_rd();
        return !rest && !flush && !fifo_empty && (ml.size() == 0 || (out_ready && ml.size() == 1));
    endfunction

    task automatic pins();
        fifo_empty     = (fq.size() == 0);
        fifo_read_data = fifo_empty ? $urandom : fq[0];
    endtask

    task automatic load_word(input logic [31:0] w);
        ml.delete();
        mm.delete();
        for (int k = 0; k < 4; k++) ml.push_back(w[k*8 +: 8]);
        for (int k = 0; k < 4; k++) mm.push_back(w[(3-k)*8 +: 8]);
    endtask

    task automatic tick();
        logic        rd, xf;
        int unsigned nsc;
        rd = exp_rd();
        xf = (ml.size() > 0) && out_ready;
        if (rest || flush || stall_clr) nsc = 0;
        else if (ml.size() > 0 && !out_ready && sc < 65535) nsc = sc + 1;
        else nsc = sc;
        @(posedge clk);
        sc = nsc;
        if (rest || flush) begin
            ml.delete();
            mm.delete();
        end else if (rd) begin
            load_word(fq.pop_front());
        end else if (xf) begin
            void'(ml.pop_front());
            void'(mm.pop_front());
        end
        @(negedge clk);
        pins();
    endtask

    task automatic settle();
        rest = 1'b0; flush = 1'b0; stall_clr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40 && (ml.size() > 0 || fq.size() > 0); i++) begin
            #1; tick();
        end
    endtask

    task automatic test_reset();
        rest = 1'b1; out_ready = 1'b0; fq.delete(); ml.delete(); mm.delete(); sc = 0;
        pins();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({v_l, last_l, rd_l, busy_l, d_l, v_m, d_m} !== 14'h0)
            begin errors++; $display("FAIL reset_idle: v=%b last=%b rd=%b busy=%b d=%h dm=%h, want all 0", v_l, last_l, rd_l, busy_l, d_l, d_m); end
`ifdef FIFO_RD_SER_STALL_CNT_EN
        checks++;
        if (sc_l !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", sc_l); end
`endif
        @(negedge clk);
        rest = 1'b0; out_ready = 1'b1;
        fq.push_back(32'hDEADBEEF); fq.push_back(32'h55667788);
        pins();
        #1; tick();
        #1; tick();
        #1;
        checks++;
        if (v_l !== 1'b1 || d_l !== 8'hBE) begin errors++; $display("FAIL reset_preword: v=%b d=%h want 1 be", v_l, d_l); end
        #1; rest = 1'b1; #1;
        ml.delete(); mm.delete(); sc = 0;
        checks++;
        if ({v_l, d_l, last_l, rd_l, v_m} !== 12'h0)
            begin errors++; $display("FAIL reset_async: v=%b d=%h last=%b rd=%b, want 0", v_l, d_l, last_l, rd_l); end
        tick();
        rest = 1'b0; #1;
        checks++;
        if (rd_l !== 1'b1) begin errors++; $display("FAIL reset_release_rd: got %b want 1", rd_l); end
        tick(); #1;
        checks++;
        if (v_l !== 1'b1 || d_l !== 8'h88 || d_m !== 8'h55)
            begin errors++; $display("FAIL reset_next_word: v=%b d=%h dm=%h want 1 88 55", v_l, d_l, d_m); end
    endtask

    task automatic test_single();
        logic [7:0] lsb_b [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        logic [7:0] msb_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        settle();
        fq.push_back(32'hA1B2C3D4); pins();
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (rd_l !== (c == 0)) begin errors++; $display("FAIL single_rd c=%0d: got %b", c, rd_l); end
            checks++;
            if (v_l !== (c >= 1 && c <= 4) || v_m !== v_l) begin errors++; $display("FAIL single_valid c=%0d: got %b/%b", c, v_l, v_m); end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (d_l !== lsb_b[c-1] || last_l !== (c == 4) || d_m !== msb_b[c-1] || last_m !== (c == 4))
                    begin errors++; $display("FAIL single_beat c=%0d: d=%h last=%b dm=%h want %h %b %h", c, d_l, last_l, d_m, lsb_b[c-1], c == 4, msb_b[c-1]); end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        settle();
        fq.push_back(32'h03020100); fq.push_back(32'h07060504); pins();
        for (int c = 0; c < 10; c++) begin
            #1;
            if (rd_l) pops++;
            checks++;
            if (rd_l !== (c == 0 || c == 4)) begin errors++; $display("FAIL b2b_rd c=%0d: got %b", c, rd_l); end
            checks++;
            if (v_l !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL b2b_valid c=%0d: got %b", c, v_l); end
            if (c >= 1 && c <= 8) begin
                checks++;
                if (d_l !== 8'(c - 1) || last_l !== (c == 4 || c == 8) || d_m !== mm[0])
                    begin errors++; $display("FAIL b2b_beat c=%0d: d=%h last=%b dm=%h want %h", c, d_l, last_l, d_m, 8'(c - 1)); end
            end
            tick();
        end
        checks++;
        if (pops != 2) begin errors++; $display("FAIL b2b_pops: got %0d want 2", pops); end
    endtask

    task automatic test_backpressure();
        logic [7:0] rest_b [4] = '{8'hC3, 8'hB2, 8'hA1, 8'h66};
        settle();
        stall_clr = 1'b1; #1; tick(); stall_clr = 1'b0;
        fq.push_back(32'hA1B2C3D4); fq.push_back(32'h99887766); pins();
        #1; tick();
        #1; tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (v_l !== 1'b1 || d_l !== 8'hC3 || last_l !== 1'b0 || rd_l !== 1'b0)
                begin errors++; $display("FAIL bp_hold i=%0d: v=%b d=%h last=%b rd=%b want 1 c3 0 0", i, v_l, d_l, last_l, rd_l); end
            tick();
        end
        #1;
`ifdef FIFO_RD_SER_STALL_CNT_EN
        checks++;
        if (sc_l !== 16'd3 || sc_m !== 16'd3) begin errors++; $display("FAIL bp_stall_cnt: got %0d/%0d want 3", sc_l, sc_m); end
`endif
        stall_clr = 1'b1; tick(); stall_clr = 1'b0; #1;
`ifdef FIFO_RD_SER_STALL_CNT_EN
        checks++;
        if (sc_l !== 16'd0) begin errors++; $display("FAIL bp_stall_clr: got %0d want 0", sc_l); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) #1;
            checks++;
            if (v_l !== 1'b1 || d_l !== rest_b[c] || rd_l !== (c == 2))
                begin errors++; $display("FAIL bp_resume c=%0d: v=%b d=%h rd=%b want 1 %h %b", c, v_l, d_l, rd_l, rest_b[c], c == 2); end
            tick();
        end
    endtask

    task automatic test_flush();
        logic [7:0] nb [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
        settle();
        fq.push_back(32'hA1B2C3D4); fq.push_back(32'h11223344); pins();
        #1; tick();
        #1;
        checks++;
        if (d_l !== 8'hD4) begin errors++; $display("FAIL flush_pre: d=%h want d4", d_l); end
        tick();
        flush = 1'b1; #1;
        checks++;
        if (rd_l !== 1'b0 || v_l !== 1'b1) begin errors++; $display("FAIL flush_cycle: rd=%b v=%b want 0 1", rd_l, v_l); end
        tick();
        flush = 1'b0; #1;
        checks++;
        if (v_l !== 1'b0 || rd_l !== 1'b1) begin errors++; $display("FAIL flush_after: v=%b rd=%b want 0 1", v_l, rd_l); end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (v_l !== 1'b1 || d_l !== nb[c] || last_l !== (c == 3))
                begin errors++; $display("FAIL flush_next c=%0d: v=%b d=%h last=%b want 1 %h", c, v_l, d_l, last_l, nb[c]); end
            tick();
        end
        settle();
        fq.push_back(32'h55AA55AA); fq.push_back(32'hCAFEF00D); pins();
        for (int i = 0; i < 4; i++) begin #1; tick(); end
        flush = 1'b1; #1;
        checks++;
        if (last_l !== 1'b1 || rd_l !== 1'b0) begin errors++; $display("FAIL flush_last_beat: last=%b rd=%b want 1 0", last_l, rd_l); end
        tick();
        flush = 1'b0; #1;
        checks++;
        if (v_l !== 1'b0 || rd_l !== 1'b1) begin errors++; $display("FAIL flush_last_after: v=%b rd=%b want 0 1", v_l, rd_l); end
        tick(); #1;
        checks++;
        if (d_l !== 8'h0D || d_m !== 8'hCA) begin errors++; $display("FAIL flush_last_next: d=%h dm=%h want 0d ca", d_l, d_m); end
    endtask

    task automatic test_empty();
        settle();
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(1));
            #1;
            checks++;
            if (rd_l !== 1'b0 || v_l !== 1'b0 || rd_m !== 1'b0)
                begin errors++; $display("FAIL empty i=%0d: rd=%b v=%b want 0 0", i, rd_l, v_l); end
            tick();
        end
    endtask

    task automatic test_random();
        settle();
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(24) == 0);
            stall_clr = ($urandom_range(39) == 0);
            if (fq.size() < 6 && $urandom_range(2) == 0) fq.push_back($urandom);
            pins();
            #1;
            checks++;
            if (rd_l !== exp_rd() || rd_m !== exp_rd())
                begin errors++; $display("FAIL rand_rd n=%0d: got %b/%b want %b", n, rd_l, rd_m, exp_rd()); end
            checks++;
            if (v_l !== (ml.size() > 0) || busy_l !== (ml.size() > 0) || v_m !== (ml.size() > 0) || busy_m !== v_m)
                begin errors++; $display("FAIL rand_valid n=%0d: v=%b busy=%b want %b", n, v_l, busy_l, ml.size() > 0); end
            if (ml.size() > 0) begin
                checks++;
                if (d_l !== ml[0] || last_l !== (ml.size() == 1) || d_m !== mm[0] || last_m !== (ml.size() == 1))
                    begin errors++; $display("FAIL rand_beat n=%0d: d=%h dm=%h last=%b want %h %h %b", n, d_l, d_m, last_l, ml[0], mm[0], ml.size() == 1); end
            end
`ifdef FIFO_RD_SER_STALL_CNT_EN
            checks++;
            if (sc_l !== 16'(sc) || sc_m !== 16'(sc))
                begin errors++; $display("FAIL rand_stall_cnt n=%0d: got %0d/%0d want %0d", n, sc_l, sc_m, sc); end
`endif
            tick();
        end
        flush = 1'b0; stall_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_empty();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
